// File: rtl/adder_seq_pkg.sv
// Shared constants and state encoding for the adder sequencer and its key debouncers.
package adder_seq_pkg;
    localparam int OPW       = 4;
    localparam int RW        = 5;
    localparam int KEY_STEP  = 0;
    localparam int KEY_CLEAR = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SHOW   = 3'd4
    } state_t;
endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low key; emits a 1-cycle pulse on each accepted press.
// Latency: 2 + DEBOUNCE_CYCLES cycles from a stable press to the pulse.
// No backpressure: the pulse is dropped if the consumer ignores it.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            press <= 1'b0;
            // Any cycle where the synced key agrees with the accepted level restarts the run.
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= ~sync2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/adder_sequencer.sv
// Steps an operator through A/B entry, drives the shared adder, latches and displays the sum.
// Latency: result latched ADD_LAT+1 cycles after entering EXEC; keys add 2+DEBOUNCE_CYCLES.
// No backpressure: STEP presses outside a state that consumes them are dropped, never queued.
module adder_sequencer
    import adder_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ADD_LAT         = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [9:0] SW,
    input  logic [1:0] KEY,
    output logic [3:0] ADD_X,
    output logic [3:0] ADD_Y,
    output logic       ADD_CIN,
    input  logic [7:0] ADD_S,
    input  logic       ADD_COUT,
    output logic [7:0] DISP_VAL,
    output logic       DISP_BLANK,
    output logic [9:0] LED,
    output logic       BUSY,
    output logic       OVF
);
    state_t          state;
    state_t          state_nxt;
    logic            step;
    logic            clear;
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
    logic            cin;
    logic [RW-1:0]   r;
    logic            ovf;
    logic [3:0]      lat_cnt;
    logic            exec_on;
    logic [2:0]      state_code;
    logic            unused_sw;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk     (CLK),
        .rst_n   (RST_N),
        .key_raw (KEY[KEY_STEP]),
        .press   (step)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk     (CLK),
        .rst_n   (RST_N),
        .key_raw (KEY[KEY_CLEAR]),
        .press   (clear)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        DISP_VAL   = '0;
        DISP_BLANK = 1'b1;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (step) state_nxt = ST_LOAD_A;
                ST_LOAD_A: if (step) state_nxt = ST_LOAD_B;
                ST_LOAD_B: if (step) state_nxt = ST_EXEC;
                ST_EXEC:   if (lat_cnt == 4'd0) state_nxt = ST_SHOW;
                ST_SHOW:   if (step) state_nxt = ST_LOAD_A;
                default:   state_nxt = ST_IDLE;
            endcase
        end
        case (state)
            ST_LOAD_A, ST_LOAD_B: begin
                DISP_VAL   = {4'h0, SW[OPW-1:0]};
                DISP_BLANK = 1'b0;
            end
            ST_SHOW: begin
                DISP_VAL   = {3'b000, r};
                DISP_BLANK = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a       <= '0;
            b       <= '0;
            cin     <= 1'b0;
            r       <= '0;
            ovf     <= 1'b0;
            lat_cnt <= '0;
        end else if (clear) begin
            a   <= '0;
            b   <= '0;
            cin <= 1'b0;
            r   <= '0;
            ovf <= 1'b0;
        end else begin
            case (state)
                ST_LOAD_A: if (step) a <= SW[OPW-1:0];
                ST_LOAD_B: if (step) begin
                    b       <= SW[OPW-1:0];
                    cin     <= SW[9];
                    lat_cnt <= 4'(ADD_LAT);
                end
                ST_EXEC: begin
                    // Carry-out and any stray upper sum bits both mean the result exceeds 4 bits.
                    if (lat_cnt == 4'd0) begin
                        r   <= ADD_S[RW-1:0];
                        ovf <= ADD_COUT | (|ADD_S[7:OPW]);
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                ST_SHOW: if (step) ovf <= 1'b0;
                default: ;
            endcase
        end
    end

    assign exec_on    = (state == ST_EXEC);
    assign state_code = state;
    assign ADD_X      = a;
    assign ADD_Y      = b;
    assign ADD_CIN    = cin;
    assign BUSY       = exec_on;
    assign OVF        = ovf;
    assign LED        = {5'b00000, ovf, exec_on, state_code};
    assign unused_sw  = ^SW[8:OPW];
endmodule

// File: tb/tb_adder_sequencer.sv
// Randomized and directed bench for adder_sequencer against a cycle-level behavioural model.
module tb_adder_sequencer;
    localparam int DB   = 4;
    localparam int LAT  = 2;
    localparam int LAT2 = 15;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [9:0] SW;
    logic [1:0] KEY;
    logic [1:0] key2;
    logic [7:0] inject;

    logic [3:0] add_x, add_y;
    logic       add_cin, add_cout;
    logic [7:0] add_s;
    logic [8:0] sum1;
    logic [7:0] disp_val;
    logic       disp_blank, busy, ovf;
    logic [9:0] led;

    logic [3:0] x2, y2;
    logic       cin2, cout2;
    logic [7:0] s2, dv2;
    logic       bl2, busy2, ovf2;
    logic [9:0] led2;
    logic [8:0] sum2;

    always #5 CLK = ~CLK;

    // Behavioural adders standing in for the shared ripple-carry adder.
    assign sum1     = {5'b0, add_x} + {5'b0, add_y} + {8'b0, add_cin} + {1'b0, inject};
    assign add_s    = sum1[7:0];
    assign add_cout = sum1[4];
    assign sum2     = {5'b0, x2} + {5'b0, y2} + {8'b0, cin2};
    assign s2       = sum2[7:0];
    assign cout2    = sum2[4];

    adder_sequencer #(.DEBOUNCE_CYCLES(DB), .ADD_LAT(LAT)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .SW(SW), .KEY(KEY),
        .ADD_X(add_x), .ADD_Y(add_y), .ADD_CIN(add_cin),
        .ADD_S(add_s), .ADD_COUT(add_cout),
        .DISP_VAL(disp_val), .DISP_BLANK(disp_blank),
        .LED(led), .BUSY(busy), .OVF(ovf)
    );

    adder_sequencer #(.DEBOUNCE_CYCLES(DB), .ADD_LAT(LAT2)) u_dut_long (
        .CLK(CLK), .RST_N(RST_N), .SW(SW), .KEY(key2),
        .ADD_X(x2), .ADD_Y(y2), .ADD_CIN(cin2),
        .ADD_S(s2), .ADD_COUT(cout2),
        .DISP_VAL(dv2), .DISP_BLANK(bl2),
        .LED(led2), .BUSY(busy2), .OVF(ovf2)
    );

    // Model: operator-visible mode (0 idle,1 load A,2 load B,3 exec,4 show) and captured values.
    int         m_st;
    logic [3:0] m_a, m_b;
    logic       m_cin;
    logic [4:0] m_r;
    logic       m_ovf;
    int         m_entry;
    int         m_sum;
    int         cyc = 0;
    logic       m_ps, m_pc;
    logic       d1[2], d2[2], lvl[2], pls[2];
    int         run[2];

    always @(posedge CLK) begin
        cyc++;
        if (!RST_N) begin
            m_st = 0; m_a = '0; m_b = '0; m_cin = 1'b0; m_r = '0; m_ovf = 1'b0; m_entry = 0;
            for (int i = 0; i < 2; i++) begin
                d1[i] = 1'b1; d2[i] = 1'b1; lvl[i] = 1'b1; pls[i] = 1'b0; run[i] = 0;
            end
        end else begin
            m_ps = pls[0];
            m_pc = pls[1];
            if (m_pc) begin
                m_st = 0; m_a = '0; m_b = '0; m_cin = 1'b0; m_r = '0; m_ovf = 1'b0;
            end else begin
                case (m_st)
                    0: if (m_ps) m_st = 1;
                    1: if (m_ps) begin m_a = SW[3:0]; m_st = 2; end
                    2: if (m_ps) begin m_b = SW[3:0]; m_cin = SW[9]; m_entry = cyc; m_st = 3; end
                    3: if (cyc - m_entry == LAT + 1) begin
                        m_sum = m_a + m_b + m_cin + inject;
                        m_r   = 5'(m_sum);
                        m_ovf = (m_sum > 15);
                        m_st  = 4;
                    end
                    4: if (m_ps) begin m_ovf = 1'b0; m_st = 1; end
                    default: m_st = 0;
                endcase
            end
            // A key is accepted after DB consecutive cycles of disagreeing with its level.
            for (int i = 0; i < 2; i++) begin
                pls[i] = 1'b0;
                if (d2[i] != lvl[i]) begin
                    run[i]++;
                    if (run[i] == DB) begin
                        lvl[i] = d2[i];
                        run[i] = 0;
                        pls[i] = ~d2[i];
                    end
                end else begin
                    run[i] = 0;
                end
                d2[i] = d1[i];
                d1[i] = KEY[i];
            end
        end
    end

    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;
    int   run_len = 0, last_run = 0, run_len2 = 0, last_run2 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [9:0] e_led;
        e_led = {5'b0, m_ovf, (m_st == 3), 3'(m_st)};
        chk("led", led, e_led);
        chk("busy", busy, (m_st == 3));
        chk("ovf", ovf, m_ovf);
        chk("adder_in", {add_cin, add_x, add_y}, {m_cin, m_a, m_b});
        if (m_st != 3) chk("blank", disp_blank, (m_st == 0));
        if (m_st == 1 || m_st == 2) chk("disp_live", disp_val, {4'h0, SW[3:0]});
        if (m_st == 4) chk("disp_res", disp_val, {3'b000, m_r});
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic press(input int idx);
        KEY[idx] = 1'b0;
        repeat (DB + 4) tick();
        KEY[idx] = 1'b1;
        repeat (DB + 4) tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int w;
        fork
            forever begin
                @(negedge CLK);
                if (chk_en) compare();
                if (busy) run_len++;
                else if (run_len != 0) begin last_run = run_len; run_len = 0; end
                if (busy2) run_len2++;
                else if (run_len2 != 0) begin last_run2 = run_len2; run_len2 = 0; end
            end
        join_none

        RST_N = 1'b0; KEY = 2'b11; key2 = 2'b11; SW = '0; inject = '0;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_led", led, 0);
        chk("rst_blank", disp_blank, 1);
        chk("rst_x", add_x, 0);
        chk("rst_y", add_y, 0);
        chk("rst_disp", disp_val, 0);
        RST_N = 1'b1;
        tick();

        // 5 + 9 + 0
        press(0); SW = 10'd5; press(0); SW = 10'd9; press(0);
        chk("s1_exec_len", last_run, 3);
        chk("s1_disp", disp_val, 14);
        chk("s1_ovf", ovf, 0);
        chk("s1_x", add_x, 5);
        chk("s1_y", add_y, 9);

        // 15 + 15 + 1 is the largest result
        press(0); SW = 10'd15; press(0); SW = 10'h20F; press(0);
        chk("s2_disp", disp_val, 31);
        chk("s2_ovf", ovf, 1);
        chk("s2_led4", led[4], 1);
        press(0);
        chk("s2_ovf_clr", ovf, 0);
        chk("s2_state", led[2:0], 1);

        // Bouncing STEP in LOAD_A: pulse 2+DB edges after stable low, state moves one edge later.
        SW = 10'd3;
        KEY[0] = 1'b0; tick(); tick();
        KEY[0] = 1'b1; tick();
        KEY[0] = 1'b0;
        acc = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (acc == 0 && led[2:0] == 3'd2) acc = k;
        end
        chk("bounce_lat", acc, DB + 3);
        chk("bounce_once", led[2:0], 2);
        KEY[0] = 1'b1;
        repeat (10) tick();

        // CLEAR lands two cycles into EXEC.
        KEY[0] = 1'b0; tick(); tick();
        KEY[1] = 1'b0;
        repeat (12) tick();
        chk("clr_exec_len", last_run, 2);
        chk("clr_led", led, 0);
        chk("clr_blank", disp_blank, 1);
        chk("clr_x", add_x, 0);
        KEY = 2'b11;
        repeat (10) tick();

        // Coincident CLEAR and STEP in LOAD_B.
        press(0); press(0);
        SW = 10'd7;
        KEY = 2'b00; repeat (DB + 4) tick();
        KEY = 2'b11; repeat (DB + 4) tick();
        chk("coin_state", led[2:0], 0);
        chk("coin_y", add_y, 0);
        chk("coin_blank", disp_blank, 1);

        // Reset asserted mid-EXEC.
        press(0); press(0);
        SW = 10'd6;
        KEY[0] = 1'b0;
        w = 0;
        while (!busy && w < 20) begin tick(); w++; end
        chk("rst_busy_seen", busy, 1);
        RST_N = 1'b0; KEY = 2'b11;
        tick();
        chk("rst2_led", led, 0);
        chk("rst2_x", add_x, 0);
        chk("rst2_blank", disp_blank, 1);
        chk("rst2_ovf", ovf, 0);
        chk("rst2_disp", disp_val, 0);
        RST_N = 1'b1;
        repeat (3) tick();

        // Random key/switch activity, occasionally with a corrupted upper adder sum.
        repeat (60) begin
            SW     = 10'($urandom);
            inject = ($urandom_range(0, 5) == 0) ? 8'h20 : 8'h00;
            KEY    = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 12)) tick();
        end
        KEY = 2'b11; inject = 8'h00;
        repeat (20) tick();

        // Long-latency instance: a fourth STEP arrives mid-EXEC and must be dropped.
        SW = 10'd2;
        repeat (4) begin
            key2 = 2'b10; repeat (7) tick();
            key2 = 2'b11; repeat (7) tick();
        end
        repeat (20) tick();
        chk("long_exec_len", last_run2, LAT2 + 1);
        chk("long_state", led2[2:0], 4);
        chk("long_disp", dv2, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
